// File: rtl/axi2per_bridge.sv
// AXI4 slave to peripheral-bus master bridge: one AXI transaction at a time,
// one 32-bit peripheral access per AXI beat.
module axi2per_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned PER_DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      axi_slave_aw_valid_i,
    output logic                      axi_slave_aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_aw_addr_i,
    input  logic [7:0]                axi_slave_aw_len_i,
    input  logic [2:0]                axi_slave_aw_size_i,
    input  logic [1:0]                axi_slave_aw_burst_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_slave_aw_id_i,
    input  logic                      axi_slave_w_valid_i,
    output logic                      axi_slave_w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] axi_slave_w_data_i,
    input  logic [7:0]                axi_slave_w_strb_i,
    input  logic                      axi_slave_w_last_i,
    output logic                      axi_slave_b_valid_o,
    input  logic                      axi_slave_b_ready_i,
    output logic [1:0]                axi_slave_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
    input  logic                      axi_slave_ar_valid_i,
    output logic                      axi_slave_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_ar_addr_i,
    input  logic [7:0]                axi_slave_ar_len_i,
    input  logic [2:0]                axi_slave_ar_size_i,
    input  logic [1:0]                axi_slave_ar_burst_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_slave_ar_id_i,
    output logic                      axi_slave_r_valid_o,
    input  logic                      axi_slave_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
    output logic [1:0]                axi_slave_r_resp_o,
    output logic                      axi_slave_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
    output logic                      per_master_req_o,
    output logic [AXI_ADDR_WIDTH-1:0] per_master_add_o,
    output logic                      per_master_we_o,
    output logic [PER_DATA_WIDTH-1:0] per_master_wdata_o,
    output logic [3:0]                per_master_be_o,
    input  logic                      per_master_gnt_i,
    input  logic                      per_master_r_valid_i,
    input  logic                      per_master_r_opc_i,
    input  logic [PER_DATA_WIDTH-1:0] per_master_r_rdata_i,
    output logic                      busy_o
);

    typedef enum logic [2:0] {
        StIdle, StRdReq, StRdWait, StRdResp, StWrData, StWrReq, StWrWait, StWrResp
    } state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    state_e                    state_q, state_d;
    logic                      prefer_wr_q, prefer_wr_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d, next_addr, step;
    logic [7:0]                len_q, len_d, cnt_q, cnt_d;
    logic [2:0]                size_q, size_d;
    logic [1:0]                burst_q, burst_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic                      err_q, err_d, bad_q, bad_d;
    logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]                r_resp_q, r_resp_d;
    logic [PER_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]                be_q, be_d;
    logic                      sel_rd, sel_wr, last_beat;

    // Round-robin only matters when both address channels are valid together.
    assign sel_rd    = axi_slave_ar_valid_i && (!axi_slave_aw_valid_i || !prefer_wr_q);
    assign sel_wr    = axi_slave_aw_valid_i && (!axi_slave_ar_valid_i || prefer_wr_q);
    assign last_beat = (cnt_q == len_q);
    assign step      = AXI_ADDR_WIDTH'(1) << size_q;
    assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + step;

    assign per_master_add_o   = {addr_q[AXI_ADDR_WIDTH-1:2], 2'b00};
    assign per_master_wdata_o = wdata_q;
    assign axi_slave_r_data_o = r_data_q;
    assign axi_slave_r_resp_o = r_resp_q;
    assign axi_slave_r_id_o   = id_q;
    assign axi_slave_b_id_o   = id_q;
    assign axi_slave_b_resp_o = err_q ? RespSlvErr : RespOkay;
    assign busy_o             = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        prefer_wr_d = prefer_wr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        bad_d       = bad_q;
        r_data_d    = r_data_q;
        r_resp_d    = r_resp_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        axi_slave_ar_ready_o = 1'b0;
        axi_slave_aw_ready_o = 1'b0;
        axi_slave_w_ready_o  = 1'b0;
        axi_slave_r_valid_o  = 1'b0;
        axi_slave_r_last_o   = 1'b0;
        axi_slave_b_valid_o  = 1'b0;
        per_master_req_o     = 1'b0;
        per_master_we_o      = 1'b0;
        per_master_be_o      = be_q;

        unique case (state_q)
            StIdle: begin
                axi_slave_ar_ready_o = sel_rd;
                axi_slave_aw_ready_o = sel_wr;
                cnt_d = 8'd0;
                if (sel_rd) begin
                    prefer_wr_d = 1'b1;
                    addr_d  = axi_slave_ar_addr_i;
                    len_d   = axi_slave_ar_len_i;
                    size_d  = axi_slave_ar_size_i;
                    burst_d = axi_slave_ar_burst_i;
                    id_d    = axi_slave_ar_id_i;
                    err_d   = 1'b0;
                    bad_d   = (axi_slave_ar_size_i > 3'd2);
                    if (axi_slave_ar_size_i > 3'd2) begin
                        r_data_d = '0;
                        r_resp_d = RespSlvErr;
                        state_d  = StRdResp;
                    end else begin
                        state_d = StRdReq;
                    end
                end else if (sel_wr) begin
                    prefer_wr_d = 1'b0;
                    addr_d  = axi_slave_aw_addr_i;
                    len_d   = axi_slave_aw_len_i;
                    size_d  = axi_slave_aw_size_i;
                    burst_d = axi_slave_aw_burst_i;
                    id_d    = axi_slave_aw_id_i;
                    err_d   = (axi_slave_aw_size_i > 3'd2);
                    bad_d   = (axi_slave_aw_size_i > 3'd2);
                    state_d = StWrData;
                end
            end
            StRdReq: begin
                per_master_req_o = 1'b1;
                per_master_be_o  = 4'hF;
                if (per_master_gnt_i) state_d = StRdWait;
            end
            StRdWait: begin
                if (per_master_r_valid_i) begin
                    r_data_d = {per_master_r_rdata_i, per_master_r_rdata_i};
                    r_resp_d = per_master_r_opc_i ? RespSlvErr : RespOkay;
                    state_d  = StRdResp;
                end
            end
            StRdResp: begin
                axi_slave_r_valid_o = 1'b1;
                axi_slave_r_last_o  = last_beat;
                if (axi_slave_r_ready_i) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = bad_q ? StRdResp : StRdReq;
                    end
                end
            end
            StWrData: begin
                axi_slave_w_ready_o = 1'b1;
                if (axi_slave_w_valid_i) begin
                    wdata_d = addr_q[2] ? axi_slave_w_data_i[63:32] : axi_slave_w_data_i[31:0];
                    be_d    = addr_q[2] ? axi_slave_w_strb_i[7:4] : axi_slave_w_strb_i[3:0];
                    if (axi_slave_w_last_i != last_beat) err_d = 1'b1;
                    if (!bad_q) begin
                        state_d = StWrReq;
                    end else if (last_beat) begin
                        state_d = StWrResp;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StWrReq: begin
                per_master_req_o = 1'b1;
                per_master_we_o  = 1'b1;
                if (per_master_gnt_i) state_d = StWrWait;
            end
            StWrWait: begin
                if (per_master_r_valid_i) begin
                    err_d = err_q | per_master_r_opc_i;
                    if (last_beat) begin
                        state_d = StWrResp;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = StWrData;
                    end
                end
            end
            StWrResp: begin
                axi_slave_b_valid_o = 1'b1;
                if (axi_slave_b_ready_i) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            prefer_wr_q <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            bad_q       <= 1'b0;
            r_data_q    <= '0;
            r_resp_q    <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            prefer_wr_q <= prefer_wr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            bad_q       <= bad_d;
            r_data_q    <= r_data_d;
            r_resp_q    <= r_resp_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
        end
    end

endmodule

// File: tb/tb_axi2per_bridge.sv
// Directed self-checking bench for axi2per_bridge: reads, write bursts,
// arbitration, peripheral errors, unsupported sizes and mid-transaction reset.
module tb_axi2per_bridge;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic [3:0]  aw_id, ar_id, b_id, r_id;
    logic [63:0] w_data, r_data;
    logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic        req, we, gnt, p_rvalid, opc, busy;
    logic [31:0] add, wdata, rdata;
    logic [3:0]  be;

    int checks = 0;
    int errors = 0;
    int req_seen = 0;
    int req_base;

    always #5 clk = ~clk;
    always @(posedge clk) if (req) req_seen++;

    axi2per_bridge dut (
        .clk_i(clk), .rst_i(rst_i),
        .axi_slave_aw_valid_i(aw_valid), .axi_slave_aw_ready_o(aw_ready),
        .axi_slave_aw_addr_i(aw_addr), .axi_slave_aw_len_i(aw_len),
        .axi_slave_aw_size_i(aw_size), .axi_slave_aw_burst_i(aw_burst),
        .axi_slave_aw_id_i(aw_id),
        .axi_slave_w_valid_i(w_valid), .axi_slave_w_ready_o(w_ready),
        .axi_slave_w_data_i(w_data), .axi_slave_w_strb_i(w_strb),
        .axi_slave_w_last_i(w_last),
        .axi_slave_b_valid_o(b_valid), .axi_slave_b_ready_i(b_ready),
        .axi_slave_b_resp_o(b_resp), .axi_slave_b_id_o(b_id),
        .axi_slave_ar_valid_i(ar_valid), .axi_slave_ar_ready_o(ar_ready),
        .axi_slave_ar_addr_i(ar_addr), .axi_slave_ar_len_i(ar_len),
        .axi_slave_ar_size_i(ar_size), .axi_slave_ar_burst_i(ar_burst),
        .axi_slave_ar_id_i(ar_id),
        .axi_slave_r_valid_o(r_valid), .axi_slave_r_ready_i(r_ready),
        .axi_slave_r_data_o(r_data), .axi_slave_r_resp_o(r_resp),
        .axi_slave_r_last_o(r_last), .axi_slave_r_id_o(r_id),
        .per_master_req_o(req), .per_master_add_o(add), .per_master_we_o(we),
        .per_master_wdata_o(wdata), .per_master_be_o(be),
        .per_master_gnt_i(gnt), .per_master_r_valid_i(p_rvalid),
        .per_master_r_opc_i(opc), .per_master_r_rdata_i(rdata),
        .busy_o(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [3:0] id);
        ar_valid = 1'b1; ar_addr = a; ar_len = l; ar_size = s; ar_burst = 2'b01; ar_id = id;
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [3:0] id);
        aw_valid = 1'b1; aw_addr = a; aw_len = l; aw_size = s; aw_burst = 2'b01; aw_id = id;
    endtask

    // Holds the prepared AR until accepted, then drops it.
    task automatic accept_ar();
        int n = 0;
        #1;
        while (!ar_ready && n < 20) begin tick(); n++; end
        check("ar_accept", ar_ready, 1'b1);
        tick();
        ar_valid = 1'b0;
    endtask

    task automatic accept_aw();
        int n = 0;
        #1;
        while (!aw_ready && n < 20) begin tick(); n++; end
        check("aw_accept", aw_ready, 1'b1);
        tick();
        aw_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!req && n < 20) begin tick(); n++; end
        check("req_seen", req, 1'b1);
    endtask

    task automatic per_read(input logic [31:0] d, input logic e, input logic [31:0] exp_add);
        wait_req();
        check("rd_add", add, exp_add);
        check("rd_we", we, 1'b0);
        gnt = 1'b1; tick(); gnt = 1'b0;
        p_rvalid = 1'b1; rdata = d; opc = e; tick();
        p_rvalid = 1'b0; opc = 1'b0;
    endtask

    task automatic per_write(input logic [31:0] exp_add, input logic [31:0] exp_wd,
                             input logic [3:0] exp_be, input logic e, input int hold);
        wait_req();
        check("wr_add", add, exp_add);
        check("wr_we", we, 1'b1);
        check("wr_wdata", wdata, exp_wd);
        check("wr_be", be, exp_be);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("wr_req_held", req, 1'b1);
            check("wr_add_held", add, exp_add);
            check("wr_wdata_held", wdata, exp_wd);
        end
        gnt = 1'b1; tick(); gnt = 1'b0;
        p_rvalid = 1'b1; opc = e; tick();
        p_rvalid = 1'b0; opc = 1'b0;
    endtask

    task automatic r_beat(input logic [63:0] d, input logic [1:0] rs, input logic l,
                          input logic [3:0] id);
        int n = 0;
        while (!r_valid && n < 20) begin tick(); n++; end
        check("r_valid", r_valid, 1'b1);
        check("r_data", r_data, d);
        check("r_resp", r_resp, rs);
        check("r_last", r_last, l);
        check("r_id", r_id, id);
        r_ready = 1'b1; tick(); r_ready = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
        int n = 0;
        while (!w_ready && n < 20) begin tick(); n++; end
        check("w_ready", w_ready, 1'b1);
        w_valid = 1'b1; w_data = d; w_strb = s; w_last = l; tick();
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic b_beat(input logic [1:0] rs, input logic [3:0] id);
        int n = 0;
        while (!b_valid && n < 20) begin tick(); n++; end
        check("b_valid", b_valid, 1'b1);
        check("b_resp", b_resp, rs);
        check("b_id", b_id, id);
        b_ready = 1'b1; tick(); b_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        aw_valid = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0; aw_id = 0;
        ar_valid = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0; ar_id = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0; r_ready = 0;
        gnt = 0; p_rvalid = 0; opc = 0; rdata = 0;
        do_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_req", req, 1'b0);
        check("rst_r_valid", r_valid, 1'b0);
        check("rst_b_valid", b_valid, 1'b0);
        check("rst_ready", {ar_ready, aw_ready, w_ready}, 3'b000);
        check("rst_r_data", r_data, 64'h0);

        // Single read with exact latency: req at T+1, r_valid_o at T+3.
        set_ar(32'h1000_0004, 8'd0, 3'd2, 4'd3);
        #1;
        check("ar_ready_comb", {ar_ready, aw_ready}, 2'b10);
        tick(); ar_valid = 1'b0;
        check("lat_req", req, 1'b1);
        check("lat_add", add, 32'h1000_0004);
        check("lat_we", we, 1'b0);
        check("lat_be", be, 4'hF);
        check("lat_busy", busy, 1'b1);
        gnt = 1'b1; tick(); gnt = 1'b0;
        check("lat_req_off", req, 1'b0);
        p_rvalid = 1'b1; rdata = 32'hDEAD_BEEF; tick(); p_rvalid = 1'b0;
        check("lat_r_valid", r_valid, 1'b1);
        r_beat(64'hDEAD_BEEF_DEAD_BEEF, 2'b00, 1'b1, 4'd3);
        check("rd_done_busy", busy, 1'b0);

        // INCR write burst, grant held off 2 cycles on beat 1.
        set_aw(32'h1000_0000, 8'd3, 3'd2, 4'd5);
        accept_aw();
        w_beat(64'hBBBB_0001_AAAA_0000, 8'hF3, 1'b0);
        per_write(32'h1000_0000, 32'hAAAA_0000, 4'h3, 1'b0, 0);
        w_beat(64'hCAFE_0004_DEAD_0004, 8'h5F, 1'b0);
        per_write(32'h1000_0004, 32'hCAFE_0004, 4'h5, 1'b0, 2);
        w_beat(64'h0102_0304_0506_0708, 8'h0C, 1'b0);
        per_write(32'h1000_0008, 32'h0506_0708, 4'hC, 1'b0, 0);
        w_beat(64'hF00D_000C_BEEF_000C, 8'hF0, 1'b1);
        per_write(32'h1000_000C, 32'hF00D_000C, 4'hF, 1'b0, 0);
        b_beat(2'b00, 4'd5);

        // Arbitration: read first after reset, then write wins the repeated pair.
        do_reset();
        set_ar(32'h2000_0000, 8'd0, 3'd2, 4'd1);
        set_aw(32'h2000_0010, 8'd0, 3'd2, 4'd2);
        #1;
        check("arb_first", {ar_ready, aw_ready}, 2'b10);
        tick(); ar_valid = 1'b0;
        per_read(32'h0000_1111, 1'b0, 32'h2000_0000);
        r_beat(64'h0000_1111_0000_1111, 2'b00, 1'b1, 4'd1);
        set_ar(32'h2000_0020, 8'd0, 3'd2, 4'd4);
        #1;
        check("arb_second", {ar_ready, aw_ready}, 2'b01);
        tick(); aw_valid = 1'b0;
        w_beat(64'h5555_6666_7777_8888, 8'hFF, 1'b1);
        per_write(32'h2000_0010, 32'h7777_8888, 4'hF, 1'b0, 0);
        b_beat(2'b00, 4'd2);
        accept_ar();
        per_read(32'h0000_2222, 1'b0, 32'h2000_0020);
        r_beat(64'h0000_2222_0000_2222, 2'b00, 1'b1, 4'd4);

        // Peripheral error on read beat 0 and on a write beat.
        set_ar(32'h3000_0000, 8'd1, 3'd2, 4'd6);
        accept_ar();
        per_read(32'h1111_1111, 1'b1, 32'h3000_0000);
        r_beat(64'h1111_1111_1111_1111, 2'b10, 1'b0, 4'd6);
        per_read(32'h2222_2222, 1'b0, 32'h3000_0004);
        r_beat(64'h2222_2222_2222_2222, 2'b00, 1'b1, 4'd6);
        set_aw(32'h3000_0100, 8'd1, 3'd2, 4'd7);
        accept_aw();
        w_beat(64'h0000_0000_1234_5678, 8'hFF, 1'b0);
        per_write(32'h3000_0100, 32'h1234_5678, 4'hF, 1'b1, 0);
        w_beat(64'h9ABC_DEF0_0000_0000, 8'hFF, 1'b1);
        per_write(32'h3000_0104, 32'h9ABC_DEF0, 4'hF, 1'b0, 0);
        b_beat(2'b10, 4'd7);

        // Unsupported size: no peripheral traffic, SLVERR responses.
        req_base = req_seen;
        set_ar(32'h3000_0200, 8'd1, 3'd3, 4'd8);
        accept_ar();
        r_beat(64'h0, 2'b10, 1'b0, 4'd8);
        r_beat(64'h0, 2'b10, 1'b1, 4'd8);
        set_aw(32'h3000_0300, 8'd1, 3'd3, 4'd9);
        accept_aw();
        w_beat(64'h1, 8'hFF, 1'b0);
        w_beat(64'h2, 8'hFF, 1'b1);
        b_beat(2'b10, 4'd9);
        check("bad_no_req", 64'(req_seen - req_base), 64'd0);

        // Reset during RD_WAIT drops the transaction; next read is normal.
        set_ar(32'h4000_0008, 8'd0, 3'd2, 4'd10);
        accept_ar();
        wait_req();
        gnt = 1'b1; tick(); gnt = 1'b0;
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_req", req, 1'b0);
        check("mid_rst_r_valid", r_valid, 1'b0);
        check("mid_rst_b_valid", b_valid, 1'b0);
        tick();
        check("mid_rst_no_r", r_valid, 1'b0);
        set_ar(32'h4000_000C, 8'd0, 3'd2, 4'd11);
        accept_ar();
        per_read(32'h5A5A_5A5A, 1'b0, 32'h4000_000C);
        r_beat(64'h5A5A_5A5A_5A5A_5A5A, 2'b00, 1'b1, 4'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi2per_bridge.md
Name: axi2per_bridge

Overview:
- AXI4 slave to cluster peripheral-bus master bridge. It lets an external AXI master, such as the host or SoC interconnect, reach cluster peripherals over the req/gnt/r_valid peripheral protocol.
- Sits beside the existing peripheral-to-AXI master bridge, as its counterpart on the cluster's AXI slave port.
- Serves one AXI transaction at a time and issues one 32-bit peripheral access per AXI beat, sequentially.

Parameters:
AXI_ADDR_WIDTH, 32, AXI and peripheral address width
AXI_DATA_WIDTH, 64, AXI data width; fixed at 64 for this block
AXI_ID_WIDTH, 4, AXI ID width
PER_DATA_WIDTH, 32, peripheral data width; fixed at 32

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
axi_slave_aw_valid_i/aw_ready_o  in/out  1  AW handshake
axi_slave_aw_addr_i  in  AXI_ADDR_WIDTH  write address
axi_slave_aw_len_i  in  8  beats-1
axi_slave_aw_size_i  in  3  beat size
axi_slave_aw_burst_i  in  2  burst type
axi_slave_aw_id_i  in  AXI_ID_WIDTH  write ID
axi_slave_w_valid_i/w_ready_o  in/out  1  W handshake
axi_slave_w_data_i  in  64  write data
axi_slave_w_strb_i  in  8  write strobes
axi_slave_w_last_i  in  1  last write beat
axi_slave_b_valid_o/b_ready_i  out/in  1  B handshake
axi_slave_b_resp_o  out  2  write response
axi_slave_b_id_o  out  AXI_ID_WIDTH  response ID
axi_slave_ar_valid_i/ar_ready_o, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_id_i  read-address channel; same widths as AW
axi_slave_r_valid_o/r_ready_i  out/in  1  R handshake
axi_slave_r_data_o  out  64  read data
axi_slave_r_resp_o  out  2  read response
axi_slave_r_last_o  out  1  last read beat
axi_slave_r_id_o  out  AXI_ID_WIDTH  read ID
per_master_req_o  out  1  peripheral request
per_master_add_o  out  AXI_ADDR_WIDTH  word-aligned address
per_master_we_o  out  1  1=write, 0=read
per_master_wdata_o  out  32  write data
per_master_be_o  out  4  byte enables
per_master_gnt_i  in  1  grant
per_master_r_valid_i  in  1  response valid
per_master_r_opc_i  in  1  1=error
per_master_r_rdata_i  in  32  read data
busy_o  out  1  transaction in progress

Behaviour:
- Reset: FSM returns to IDLE. All ready/valid/req outputs, busy_o, resp, last, data and address registers are 0. The round-robin pointer resets to read-first. A reset in mid-transaction discards the transaction and no B or R response is issued.
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_WAIT, WR_RESP.
- IDLE, address acceptance:
  - ar_ready_o/aw_ready_o are combinational. Only the selected channel is asserted, and only in IDLE.
  - If only one channel is valid, it is selected.
  - If both are valid, the channel not served last is selected; the pointer updates on each accept.
  - On accept, latch addr, len, size, burst and id, clear beat counter and error flag, then go to RD_REQ or WR_DATA.
- Unsupported size (size > 2): the request is marked bad and no peripheral access is made.
  - Read: each beat goes straight to RD_RESP with data 0 and resp SLVERR.
  - Write: all beats are consumed in WR_DATA and B returns SLVERR.
- RD_REQ:
  - req=1, we=0, add={addr[31:2],2'b00}, be=4'hF.
  - add/we/wdata/be are held stable until gnt; on gnt go to RD_WAIT.
- RD_WAIT:
  - req=0; wait for per_master_r_valid_i, which is never in the grant cycle.
  - Capture rdata into both halves of r_data. resp = r_opc ? SLVERR : OKAY. Go to RD_RESP.
- RD_RESP:
  - r_valid_o=1; data, resp, id and last are stable until r_ready_i.
  - r_last_o=1 iff beat counter == len.
  - On handshake: if last, go to IDLE; else advance address and go to RD_REQ.
- WR_DATA:
  - w_ready_o=1. On w_valid, latch the 32-bit half selected by addr[2] (data[63:32]/strb[7:4] if addr[2]=1, else [31:0]/[3:0]).
  - Go to WR_REQ, or stay in WR_DATA if the burst is bad.
  - If w_last_i differs from (counter==len), set the error flag; beat count always follows len.
- WR_REQ:
  - req=1, we=1, be = latched strobes.
  - be==0 still issues the access.
  - On gnt go to WR_WAIT.
- WR_WAIT: on r_valid, OR r_opc into the error flag. Go to WR_RESP if last, else advance address and go to WR_DATA.
- WR_RESP: b_valid_o=1, b_resp = error ? SLVERR(2'b10) : OKAY, b_id = latched id. Hold until b_ready_i, then go to IDLE.
- Address advance:
  - FIXED: unchanged.
  - INCR and WRAP (WRAP is treated as INCR): addr += (1<<size), computed modulo 2^AXI_ADDR_WIDTH so it wraps at the top of the address space.
- Latency: AR accept at cycle T, req at T+1. With gnt at T+1 and r_valid at T+2, r_valid_o is asserted at T+3.
- busy_o = (state != IDLE). Only one peripheral request is outstanding at any time.

Test Plan:
- Single read: AR addr=0x1000_0004, len=0, size=2, id=3; peripheral returns 0xDEADBEEF → R data=0xDEADBEEF_DEADBEEF, resp=OKAY, last=1, id=3; per add=0x1000_0004, we=0.
- INCR write burst: AW addr=0x1000_0000, len=3, size=2, followed by four W beats. The bench holds gnt low for 2 cycles on beat 1 → four peripheral writes at 0x..00/04/08/0C with halves chosen by addr[2] and req held stable while gnt is low; one B with OKAY.
- Simultaneous AR and AW valid after reset → read served first, then write. A repeat of the same pair serves the write first.
- Peripheral error: read of len=1 with r_opc=1 on beat 0 → beat0 SLVERR, beat1 OKAY. Write with r_opc=1 on any beat → B SLVERR.
- size=3 read of len=1 → two R beats with data 0 and resp SLVERR, no per req. size=3 write → W beats consumed, no req, B SLVERR.
- Assert rst_i during RD_WAIT → next cycle state is IDLE with req, r_valid, b_valid and busy_o all 0; a subsequent read completes normally.
